// File: rtl/dual_port_lutram_pipelined.sv
// Simple dual-port LUTRAM with byte-masked writes, a READ_LATENCY-deep read pipeline,
// optional same-edge write forwarding and a zero-clear sweep after reset.
// Ports:
//   clk_in, reset_in (async, active-low)
//   init_done_out (sweep finished)
//   write_en_in / write_set_addr_in / write_entry_in (write port)
//   read_en_in / read_set_addr_in (read request)
//   read_entry_out / read_valid_out (read result)
module dual_port_lutram_pipelined #(
  parameter int SINGLE_ENTRY_WIDTH_IN_BITS = 64,
  parameter int BYTE_LEN_IN_BITS           = 8,
  parameter int NUM_SET                    = 64,
  parameter int SET_PTR_WIDTH_IN_BITS      = $clog2(NUM_SET),
  parameter int WRITE_MASK_LEN             =
    SINGLE_ENTRY_WIDTH_IN_BITS / BYTE_LEN_IN_BITS,
  parameter int READ_LATENCY               = 1,
  parameter bit WRITE_THROUGH              = 1'b1
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  output logic                                  init_done_out,
  input  logic [WRITE_MASK_LEN-1:0]             write_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      write_set_addr_in,
  input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] write_entry_in,
  input  logic                                  read_en_in,
  input  logic [SET_PTR_WIDTH_IN_BITS-1:0]      read_set_addr_in,
  output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] read_entry_out,
  output logic                                  read_valid_out
);

  localparam int W    = SINGLE_ENTRY_WIDTH_IN_BITS;
  localparam int BL   = BYTE_LEN_IN_BITS;
  localparam int ML   = WRITE_MASK_LEN;
  localparam int PW   = SET_PTR_WIDTH_IN_BITS;
  localparam int RL   = READ_LATENCY;
  localparam int LAST = NUM_SET - 1;

  localparam logic [PW:0]   NUM_SET_EXT = NUM_SET[PW:0];
  localparam logic [PW-1:0] LAST_PTR    = LAST[PW-1:0];

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ready;

  assign ready         = (state_q == ST_READY);
  assign init_done_out = ready;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (1'b1)
      (state_q == ST_CLEAR): begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) state_d = ST_READY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  logic wr_in_range;
  logic rd_in_range;

  assign wr_in_range = ({1'b0, write_set_addr_in} < NUM_SET_EXT);
  assign rd_in_range = ({1'b0, read_set_addr_in} < NUM_SET_EXT);

  // Storage write port: the clear sweep owns it until the array is zeroed.
  logic [ML-1:0] mem_we;
  logic [PW-1:0] mem_waddr;
  logic [W-1:0]  mem_wdata;

  always_comb begin
    mem_we    = '0;
    mem_waddr = write_set_addr_in;
    mem_wdata = write_entry_in;
    if (!reset_in) begin
      mem_we = '0;
    end else if (!ready) begin
      mem_we    = '1;
      mem_waddr = ptr_q;
      mem_wdata = '0;
    end else if (wr_in_range) begin
      mem_we = write_en_in;
    end
  end

  logic [W-1:0] mem_q [NUM_SET];

  always_ff @(posedge clk_in) begin
    for (int b = 0; b < ML; b++) begin
      if (mem_we[b]) mem_q[mem_waddr][b*BL +: BL] <= mem_wdata[b*BL +: BL];
    end
  end

  // Read data seen by the accept edge; stored value is pre-write.
  logic         rd_accept;
  logic         fwd_hit;
  logic [W-1:0] rd_data;

  assign rd_accept = ready && read_en_in;
  assign fwd_hit   = WRITE_THROUGH && ready && wr_in_range &&
                     (write_set_addr_in == read_set_addr_in);

  always_comb begin
    rd_data = rd_in_range ? mem_q[read_set_addr_in] : '0;
    for (int b = 0; b < ML; b++) begin
      if (fwd_hit && write_en_in[b]) begin
        rd_data[b*BL +: BL] = write_entry_in[b*BL +: BL];
      end
    end
  end

  // Each stage loads only behind a valid, so the last stage holds its
  // data between results.
  logic [W-1:0]  pipe_data_q [RL];
  logic [W-1:0]  pipe_data_d [RL];
  logic [RL-1:0] pipe_vld_q, pipe_vld_d;

  always_comb begin
    pipe_data_d    = pipe_data_q;
    pipe_vld_d     = '0;
    pipe_vld_d[0]  = rd_accept;
    if (rd_accept) pipe_data_d[0] = rd_data;
    for (int s = 1; s < RL; s++) begin
      pipe_vld_d[s] = pipe_vld_q[s-1];
      if (pipe_vld_q[s-1]) pipe_data_d[s] = pipe_data_q[s-1];
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      pipe_vld_q <= '0;
      for (int s = 0; s < RL; s++) pipe_data_q[s] <= '0;
    end else begin
      pipe_vld_q <= pipe_vld_d;
      for (int s = 0; s < RL; s++) pipe_data_q[s] <= pipe_data_d[s];
    end
  end

  assign read_valid_out = pipe_vld_q[RL-1];
  assign read_entry_out = pipe_data_q[RL-1];

endmodule

// File: tb/tb_dual_port_lutram_pipelined.sv
// Bench for dual_port_lutram_pipelined: two instances (64 sets/lat 1/forwarding,
// 48 sets/lat 3/no forwarding) driven by shared stimulus against an array model.
module tb_dual_port_lutram_pipelined;

  localparam int EMAX = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  wen = '0;
  logic [5:0]  waddr = '0;
  logic [5:0]  raddr = '0;
  logic [63:0] wdata = '0;
  logic        ren = 1'b0;

  logic [1:0]  init_done;
  logic [1:0]  rvalid;
  logic [63:0] rdata0, rdata1;

  always #5 clk = ~clk;

  dual_port_lutram_pipelined #(
    .NUM_SET(64), .READ_LATENCY(1), .WRITE_THROUGH(1'b1)
  ) u_dut0 (
    .clk_in(clk), .reset_in(rst_n), .init_done_out(init_done[0]),
    .write_en_in(wen), .write_set_addr_in(waddr), .write_entry_in(wdata),
    .read_en_in(ren), .read_set_addr_in(raddr),
    .read_entry_out(rdata0), .read_valid_out(rvalid[0])
  );

  dual_port_lutram_pipelined #(
    .NUM_SET(48), .READ_LATENCY(3), .WRITE_THROUGH(1'b0)
  ) u_dut1 (
    .clk_in(clk), .reset_in(rst_n), .init_done_out(init_done[1]),
    .write_en_in(wen), .write_set_addr_in(waddr), .write_entry_in(wdata),
    .read_en_in(ren), .read_set_addr_in(raddr),
    .read_entry_out(rdata1), .read_valid_out(rvalid[1])
  );

  int total = 0;
  int bad = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic int nset_of(int k);
    return (k == 0) ? 64 : 48;
  endfunction

  function automatic bit wt_of(int k);
    return (k == 0);
  endfunction

  function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] nw,
                                        logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  logic [63:0] mmem  [2][64];
  int          sweep_left [2];
  logic [63:0] last_d [2];
  logic        exp_v [2][EMAX];
  logic [63:0] exp_d [2][EMAX];
  int          edge_n = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      sweep_left[k] = nset_of(k);
      last_d[k] = '0;
      for (int i = 0; i < 64; i++) mmem[k][i] = '0;
      for (int i = edge_n; i < EMAX; i++) exp_v[k][i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [63:0] v;
    for (int k = 0; k < 2; k++) begin
      if (sweep_left[k] > 0) begin
        sweep_left[k]--;
      end else begin
        if (ren) begin
          v = (int'(raddr) < nset_of(k)) ? mmem[k][raddr] : 64'h0;
          if (wt_of(k) && waddr == raddr && int'(waddr) < nset_of(k))
            v = merge(v, wdata, wen);
          exp_v[k][edge_n + lat_of(k) - 1] = 1'b1;
          exp_d[k][edge_n + lat_of(k) - 1] = v;
        end
        if (int'(waddr) < nset_of(k))
          mmem[k][waddr] = merge(mmem[k][waddr], wdata, wen);
      end
    end
  endtask

  task automatic check_outputs();
    logic [63:0] rd;
    for (int k = 0; k < 2; k++) begin
      rd = (k == 0) ? rdata0 : rdata1;
      check($sformatf("init%0d@%0d", k, edge_n), 64'(init_done[k]),
            64'(sweep_left[k] == 0));
      if (exp_v[k][edge_n]) begin
        check($sformatf("valid%0d@%0d", k, edge_n), 64'(rvalid[k]), 64'd1);
        check($sformatf("data%0d@%0d", k, edge_n), rd, exp_d[k][edge_n]);
        last_d[k] = exp_d[k][edge_n];
      end else begin
        check($sformatf("valid%0d@%0d", k, edge_n), 64'(rvalid[k]), 64'd0);
        check($sformatf("hold%0d@%0d", k, edge_n), rd, last_d[k]);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (rst_n) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    ren = 1'b0;
    wen = '0;
  endtask

  task automatic rand_inputs();
    wen   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
    waddr = 6'($urandom);
    raddr = ($urandom_range(0, 3) == 0) ? waddr : 6'($urandom);
    ren   = 1'($urandom);
    wdata = {$urandom, $urandom};
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) begin
      wen = '0;
      ren = 1'b1;
      raddr = 6'(a);
      step();
    end
    idle();
    repeat (4) step();
  endtask

  initial begin
    model_reset();
    #1;
    check_outputs();
    repeat (3) step();
    rst_n = 1'b1;

    // inputs during the sweep must be ignored
    repeat (70) begin
      rand_inputs();
      step();
    end
    idle();
    read_all();

    // full-mask write at top address, then read it back
    wen = 8'hFF; waddr = 6'd63; wdata = 64'hFFFFFFFF_00000000;
    step();
    idle();
    ren = 1'b1; raddr = 6'd63;
    step();
    check("t2_valid", 64'(rvalid[0]), 64'd1);
    check("t2_data", rdata0, 64'hFFFFFFFF_00000000);
    idle();
    repeat (3) step();

    // partial byte mask
    wen = 8'hFF; waddr = 6'd62; wdata = 64'h0;
    step();
    wen = 8'hCC; wdata = 64'hFFFFFFFF_FFFFFFFF;
    step();
    idle();
    ren = 1'b1; raddr = 6'd62;
    step();
    check("t3_data", rdata0, 64'hFFFF0000_FFFF0000);
    idle();
    repeat (3) step();

    // same-edge write and read
    wen = 8'hFF; waddr = 6'd5; wdata = 64'h0;
    step();
    wen = 8'h0F; wdata = 64'hA5A5A5A5_A5A5A5A5; ren = 1'b1; raddr = 6'd5;
    step();
    check("t4_wt1", rdata0, 64'h00000000_A5A5A5A5);
    idle();
    step();
    step();
    check("t4_wt0_valid", 64'(rvalid[1]), 64'd1);
    check("t4_wt0", rdata1, 64'h0);
    repeat (2) step();

    // back-to-back reads
    for (int a = 0; a < 3; a++) begin
      ren = 1'b1; raddr = 6'(a);
      step();
    end
    idle();
    repeat (4) step();

    repeat (400) begin
      rand_inputs();
      step();
    end
    idle();
    repeat (4) step();

    // reset mid-sweep, asserted away from the clock edge
    #2;
    assert_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (30) begin
      rand_inputs();
      step();
    end
    #2;
    assert_reset();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (70) begin
      rand_inputs();
      step();
    end
    idle();
    read_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
